multiplicador_acumulador_sat: RTL and testbench
===============================================

Name: multiplicador_acumulador_sat

Overview:
- Pipelined signed fixed-point multiply-accumulate unit with saturation. It is the clocked, parametrised successor to the team's combinational saturating multiplier.
- Accepts one A×B sample per cycle. Produces either the saturated product or a saturated running sum, plus an overflow flag.
- Sits in the datapath between the operand registers and the result/display logic.

Parameters:
- Width, 8: total bits of A, B and Y (two's complement).
- Presicion, 4: fractional bits. Format is Q(Width-Presicion-1).Presicion. Legal range 0 ≤ Presicion ≤ Width-2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  A, B, clear and acumular are valid this cycle.
- clear  input  1  accumulator base is zero for this sample. Sampled only when in_valid=1.
- acumular  input  1  1: Y = sat(acc + product). 0: Y = sat(product). Sampled only when in_valid=1.
- A  input  Width  signed multiplicand.
- B  input  Width  signed multiplier.
- Y  output  Width  signed registered result; also serves as the accumulator.
- out_valid  output  1  Y updated this cycle (single-cycle pulse per sample).
- overflow  output  1  saturation occurred in the result flagged by out_valid.

Behaviour:
- Reset (rst_n=0, asynchronous): Y=0, out_valid=0, overflow=0, stage-1 valid=0. In-flight samples are discarded. Operation resumes on the first rising edge after deassertion.
- No backpressure. Throughput is 1 sample/cycle. Latency is 2: a sample with in_valid at edge N gives out_valid=1 after edge N+2.
- Stage 1 (registered):
  - P = A*B, full 2*Width-bit signed.
  - clear, acumular and the valid bit are registered alongside P.
- Stage 2 (registered into Y/out_valid/overflow):
  - Scale: S = P >>> Presicion (arithmetic shift, floor). S is computed at full width, with no truncation before the saturation check.
  - Product saturation:
    - MAX = 2^(Width-1)-1, MIN = -2^(Width-1). MIN is the true two's-complement minimum, not a symmetric clip.
    - S > MAX → MAX. S < MIN → MIN. Otherwise S[Width-1:0].
    - Call the result Ps; set pov=1 if clipped.
  - Base: 0 if clear=1 or acumular=0; otherwise the current Y.
  - Sum: Width+1-bit signed base + Ps, saturated to [MIN, MAX]. sov=1 if clipped.
  - Y ← saturated sum. out_valid ← 1. overflow ← pov | sov.
  - Base uses Y as updated by the immediately preceding sample, so back-to-back accumulate is correct with no bubble.
- Stage-2 valid=0: Y holds, out_valid ← 0, overflow ← 0.
- Saturation of the product: Ps is clipped first, then added. Positive product overflow with a negative accumulator therefore adds MAX, not the true product.
- clear=1 with acumular=1: Y = Ps (start of a new sum). clear=1 with acumular=0: same result.
- in_valid=0: clear and acumular are ignored. There is no standalone clear; issue a sample with A=0 and clear=1.
- Edge operands:
  - MIN*MIN gives a positive overflow → MAX.
  - MIN*(-1 LSB-scaled value) follows the same rules.
  - Zero operands never set overflow.

Optional Feature:
- Macro MULT_ACUM_REDONDEO_EN.
- Defined: the scale step is round-half-up. S = (P + 2^(Presicion-1)) >>> Presicion, computed in 2*Width+1 bits so the addition cannot wrap. Saturation applies after rounding. No effect when Presicion=0.
- Undefined: floor (plain arithmetic shift) as above.
- Latency, ports and all other behaviour are identical in both builds.

Test Plan (Width=8, Presicion=4):
1. Plain product: A=0x20 (2.0), B=0x30 (3.0), acumular=0 → out_valid exactly 2 cycles later, Y=0x60 (6.0), overflow=0.
2. Product saturation:
   - A=0x40 (4.0), B=0x30 (3.0) → Y=0x7F, overflow=1.
   - A=0xC0 (-4.0), B=0x30 → Y=0x80, overflow=1.
   - A=0x80, B=0x80 → Y=0x7F, overflow=1.
3. Back-to-back accumulate, consecutive cycles, all with A=0x20 (2.0):
   - clear=1, acumular=1, B=0x20 → Y=0x40.
   - acumular=1, B=0x20 → Y=0x7F, overflow=1.
   - acumular=1, B=0xE0 (-2.0) → Y=0x3F, overflow=0.
   - Expect three consecutive out_valid pulses.
4. Rounding/floor:
   - A=0x01, B=0x08 → Y=0x00 without the macro, Y=0x01 with MULT_ACUM_REDONDEO_EN.
   - A=0xFF, B=0x08 → Y=0xFF without the macro, Y=0x00 with it.
5. Reset mid-stream: issue 3 valid samples, pull rst_n low asynchronously between edges → Y=0, out_valid=0, overflow=0 immediately. After release, no stale out_valid appears; the next sample behaves as in test 1.
6. Gaps: in_valid=0 for 5 cycles with clear=1 and acumular=1 toggling → Y holds its prior value, out_valid=0, and the accumulator is not cleared.

Source files
------------

// File: rtl/multiplicador_acumulador_sat.sv
// Two-stage pipelined signed fixed-point multiply-accumulate with saturation.
// Define MULT_ACUM_REDONDEO_EN to make the scale step round-half-up instead of floor.
module multiplicador_acumulador_sat #(
    parameter int Width     = 8,
    parameter int Presicion = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             clear,
    input  logic             acumular,
    input  logic [Width-1:0] A,
    input  logic [Width-1:0] B,
    output logic [Width-1:0] Y,
    output logic             out_valid,
    output logic             overflow
);

    localparam int PW = 2 * Width;
    localparam int SW = 2 * Width + 1;

    localparam logic signed [Width-1:0] Y_MAX = {1'b0, {(Width-1){1'b1}}};
    localparam logic signed [Width-1:0] Y_MIN = {1'b1, {(Width-1){1'b0}}};
    localparam logic signed [SW-1:0]    S_MAX = {{(SW-Width+1){1'b0}}, {(Width-1){1'b1}}};
    localparam logic signed [SW-1:0]    S_MIN = {{(SW-Width+1){1'b1}}, {(Width-1){1'b0}}};

`ifdef MULT_ACUM_REDONDEO_EN
    localparam int                   RND_SH = (Presicion > 0) ? Presicion - 1 : 0;
    localparam logic signed [SW-1:0] RND    = SW'(Presicion > 0) << RND_SH;
`endif

    // Stage 1: full-width product plus control bits
    logic signed [PW-1:0] p_d, p_q;
    logic                 valid_d, valid_q;
    logic                 clear_d, clear_q;
    logic                 acum_d, acum_q;

    // Stage 2: scale, saturate, accumulate
    logic signed [SW-1:0]    p_ext, s_full;
    logic signed [Width-1:0] ps, base, y_sat;
    logic signed [Width:0]   sum;
    logic                    pov, sov;
    logic signed [Width-1:0] y_d, y_q;
    logic                    out_valid_d, out_valid_q;
    logic                    overflow_d, overflow_q;

    always_comb begin
        p_d     = $signed(A) * $signed(B);
        valid_d = in_valid;
        clear_d = clear;
        acum_d  = acumular;
    end

    // NOTE: every signal gets a default before any branch so no latch is inferred.
    always_comb begin
        p_ext = {p_q[PW-1], p_q};
`ifdef MULT_ACUM_REDONDEO_EN
        s_full = (p_ext + RND) >>> Presicion;
`else
        s_full = p_ext >>> Presicion;
`endif
        pov = 1'b0;
        ps  = s_full[Width-1:0];
        if (s_full > S_MAX) begin
            ps  = Y_MAX;
            pov = 1'b1;
        end else if (s_full < S_MIN) begin
            ps  = Y_MIN;
            pov = 1'b1;
        end

        // The clipped product is added, never the raw one.
        base  = (clear_q || !acum_q) ? '0 : y_q;
        sum   = {base[Width-1], base} + {ps[Width-1], ps};
        sov   = 1'b0;
        y_sat = sum[Width-1:0];
        if (sum[Width] != sum[Width-1]) begin
            sov   = 1'b1;
            y_sat = sum[Width] ? Y_MIN : Y_MAX;
        end

        y_d         = y_q;
        out_valid_d = 1'b0;
        overflow_d  = 1'b0;
        if (valid_q) begin
            y_d         = y_sat;
            out_valid_d = 1'b1;
            overflow_d  = pov | sov;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q         <= '0;
            valid_q     <= 1'b0;
            clear_q     <= 1'b0;
            acum_q      <= 1'b0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            p_q         <= p_d;
            valid_q     <= valid_d;
            clear_q     <= clear_d;
            acum_q      <= acum_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign Y         = y_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_multiplicador_acumulador_sat.sv
// Scoreboard bench for multiplicador_acumulador_sat (Width=8, Presicion=4).
// Expected results are queued at drive time and popped when out_valid pulses.
module tb_multiplicador_acumulador_sat;

    localparam int W    = 8;
    localparam int PREC = 4;

    typedef struct packed {
        logic [W-1:0] y;
        logic         ov;
        int           due;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         clear = 1'b0;
    logic         acumular = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [W-1:0] Y;
    logic         out_valid;
    logic         overflow;

    int   n_cmp = 0;
    int   n_err = 0;
    int   edge_cnt = 0;
    int   acc_m = 0;
    exp_t sb_q[$];

    multiplicador_acumulador_sat #(.Width(W), .Presicion(PREC)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .clear(clear),
        .acumular(acumular), .A(A), .B(B), .Y(Y),
        .out_valid(out_valid), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt++;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour in plain integer arithmetic.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic clr, input logic acc_en,
                         output logic [W-1:0] y, output logic ov);
        int p, s, ps, base, sum, sat;
        p = int'($signed(a)) * int'($signed(b));
`ifdef MULT_ACUM_REDONDEO_EN
        if (PREC > 0) p = p + (1 << (PREC - 1));
`endif
        s    = p >>> PREC;
        ps   = (s > 127) ? 127 : (s < -128) ? -128 : s;
        base = (clr || !acc_en) ? 0 : acc_m;
        sum  = base + ps;
        sat  = (sum > 127) ? 127 : (sum < -128) ? -128 : sum;
        ov   = (ps != s) || (sat != sum);
        y    = W'(sat);
        acc_m = sat;
    endtask

    task automatic monitor();
        exp_t e;
        if (out_valid) begin
            if (sb_q.size() == 0) begin
                check("spurious_out_valid", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("latency", edge_cnt, e.due);
                check("y", int'(Y), int'(e.y));
                check("overflow", int'(overflow), int'(e.ov));
            end
        end else if (sb_q.size() != 0 && sb_q[0].due <= edge_cnt) begin
            e = sb_q.pop_front();
            check("missing_out_valid", 0, 1);
        end
    endtask

    task automatic step(input logic v, input logic clr, input logic acc,
                        input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t         e;
        logic [W-1:0] y;
        logic         ov;
        @(negedge clk);
        monitor();
        in_valid = v;
        clear    = clr;
        acumular = acc;
        A        = a;
        B        = b;
        if (v) begin
            model(a, b, clr, acc, y, ov);
            e.y   = y;
            e.ov  = ov;
            e.due = edge_cnt + 2;
            sb_q.push_back(e);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 6 && sb_q.size() != 0; i++)
            step(1'b0, 1'b0, 1'b0, W'($urandom), W'($urandom));
        if (sb_q.size() != 0) check("drain_timeout", sb_q.size(), 0);
        step(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_y", int'(Y), 0);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_overflow", int'(overflow), 0);
        rst_n = 1'b1;

        // Plain product and product saturation
        step(1'b1, 1'b0, 1'b0, 8'h20, 8'h30);
        drain();
        step(1'b1, 1'b0, 1'b0, 8'h40, 8'h30);
        step(1'b1, 1'b0, 1'b0, 8'hC0, 8'h30);
        step(1'b1, 1'b0, 1'b0, 8'h80, 8'h80);
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h80);
        drain();

        // Back-to-back accumulate with no bubble
        step(1'b1, 1'b1, 1'b1, 8'h20, 8'h20);
        step(1'b1, 1'b0, 1'b1, 8'h20, 8'h20);
        step(1'b1, 1'b0, 1'b1, 8'h20, 8'hE0);
        drain();

        // Gap: controls toggle with in_valid low, accumulator must survive
        for (int i = 0; i < 5; i++) begin
            step(1'b0, i[0], ~i[0], W'($urandom), W'($urandom));
            check("gap_hold_y", int'(Y), acc_m & 8'hFF);
            check("gap_out_valid", int'(out_valid), 0);
        end
        step(1'b1, 1'b0, 1'b1, 8'h20, 8'h10);
        drain();

        // Floor vs round-half-up
        step(1'b1, 1'b0, 1'b0, 8'h01, 8'h08);
        step(1'b1, 1'b0, 1'b0, 8'hFF, 8'h08);
        drain();
`ifdef MULT_ACUM_REDONDEO_EN
        check("round_const_acc", acc_m, 0);
`else
        check("floor_const_acc", acc_m, -1);
`endif

        // Asynchronous reset with samples in flight
        step(1'b1, 1'b1, 1'b1, 8'h30, 8'h20);
        step(1'b1, 1'b0, 1'b1, 8'h30, 8'h20);
        step(1'b1, 1'b0, 1'b1, 8'h30, 8'h20);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_y", int'(Y), 0);
        check("async_rst_out_valid", int'(out_valid), 0);
        check("async_rst_overflow", int'(overflow), 0);
        sb_q.delete();
        acc_m    = 0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, 1'b0, 8'h20, 8'h30);
        drain();
        check("post_reset_y", int'(Y), 8'h60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
